// File: rtl/shift_op_sequencer_pkg.sv
// Shared types for the ARM7 operand-2 shifter: shift kinds, sequencer states
// and the normalised request consumed by the shift core.
package arm_shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'd0,
    SHIFT_LSR = 2'd1,
    SHIFT_ASR = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RS_REQ,
    ST_RS_WAIT,
    ST_RESULT
  } seq_state_e;

  typedef struct packed {
    shift_type_e shift_type;
    logic [7:0]  amount;
    logic        rrx;
  } shift_req_t;

endpackage

// File: rtl/shift_op_sequencer_if.sv
// Bus between decode/regfile/ALU and the operand-2 sequencer.
// master = surrounding pipeline, slave = sequencer.
interface shift_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        imm_form;
  logic [11:0] instr_op2;
  logic [31:0] rm_data;
  logic        c_in;
  logic        rs_rd_en;
  logic [3:0]  rs_rd_addr;
  logic [31:0] rs_rd_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_carry;

  modport master (
    output req_valid, imm_form, instr_op2, rm_data, c_in, rs_rd_data, res_ready,
    input  req_ready, rs_rd_en, rs_rd_addr, res_valid, res_data, res_carry
  );

  modport slave (
    input  req_valid, imm_form, instr_op2, rm_data, c_in, rs_rd_data, res_ready,
    output req_ready, rs_rd_en, rs_rd_addr, res_valid, res_data, res_carry
  );
endinterface

// File: rtl/shift_op_sequencer_core.sv
// Combinational barrel shifter implementing every ARM amount rule
// (0, 32, >32, RRX) for a normalised shift request.
module arm_shift_core
  import arm_shift_pkg::*;
(
  input  shift_req_t  req,
  input  logic [31:0] rm,
  input  logic        c_in,
  output logic [31:0] result,
  output logic        carry
);

  logic [4:0]  amt5;
  logic        big;
  logic        exact32;
  logic [32:0] lsl_ext;
  logic [32:0] lsr_ext;
  logic [32:0] asr_ext;
  logic [31:0] ror_res;

  assign amt5    = req.amount[4:0];
  assign big     = |req.amount[7:5];
  assign exact32 = (req.amount == 8'd32);

  // Extra bit on the shifted-out side holds the last bit lost, i.e. the carry
  assign lsl_ext = {1'b0, rm} << amt5;
  assign lsr_ext = {rm, 1'b0} >> amt5;
  assign asr_ext = $signed({rm, 1'b0}) >>> amt5;
  assign ror_res = 32'({rm, rm} >> amt5);

  always_comb begin
    result = rm;
    carry  = c_in;
    if (req.rrx) begin
      result = {c_in, rm[31:1]};
      carry  = rm[0];
    end else if (req.amount != 8'd0) begin
      case (req.shift_type)
        SHIFT_LSL: begin
          if (!big) begin
            result = lsl_ext[31:0];
            carry  = lsl_ext[32];
          end else begin
            result = 32'd0;
            carry  = exact32 ? rm[0] : 1'b0;
          end
        end
        SHIFT_LSR: begin
          if (!big) begin
            result = lsr_ext[32:1];
            carry  = lsr_ext[0];
          end else begin
            result = 32'd0;
            carry  = exact32 ? rm[31] : 1'b0;
          end
        end
        SHIFT_ASR: begin
          if (!big) begin
            result = asr_ext[32:1];
            carry  = asr_ext[0];
          end else begin
            result = {32{rm[31]}};
            carry  = rm[31];
          end
        end
        SHIFT_ROR: begin
          // A multiple of 32 leaves Rm intact, and bit 31 is then Rm[31] anyway
          result = ror_res;
          carry  = ror_res[31];
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_op_sequencer.sv
// Operand-2 sequencer: accepts decode requests, fetches Rs when needed,
// normalises the encoding and holds the shifter result until consumed.
module shift_op_sequencer
  import arm_shift_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  shift_op_sequencer_if.slave bus
);

  seq_state_e  state;
  shift_type_e cap_type;
  logic [31:0] cap_rm;
  logic        cap_cin;

  shift_req_t  core_req;
  logic [31:0] core_rm;
  logic        core_cin;
  logic [31:0] core_result;
  logic        core_carry;

  // In RS_WAIT the core runs on captured operands; otherwise on the live request
  always_comb begin
    core_req  = '{shift_type: SHIFT_LSL, amount: 8'd0, rrx: 1'b0};
    core_rm   = bus.rm_data;
    core_cin  = bus.c_in;
    if (state == ST_RS_WAIT) begin
      core_req = '{shift_type: cap_type, amount: bus.rs_rd_data[7:0], rrx: 1'b0};
      core_rm  = cap_rm;
      core_cin = cap_cin;
    end else if (bus.imm_form) begin
      core_req = '{shift_type: SHIFT_ROR,
                   amount: {3'b000, bus.instr_op2[11:8], 1'b0}, rrx: 1'b0};
      core_rm  = {24'd0, bus.instr_op2[7:0]};
    end else begin
      core_req.shift_type = shift_type_e'(bus.instr_op2[6:5]);
      core_req.amount     = {3'b000, bus.instr_op2[11:7]};
      if (bus.instr_op2[11:7] == 5'd0) begin
        case (shift_type_e'(bus.instr_op2[6:5]))
          SHIFT_LSR, SHIFT_ASR: core_req.amount = 8'd32;
          SHIFT_ROR:            core_req.rrx    = 1'b1;
          default:              core_req.amount = 8'd0;
        endcase
      end
    end
  end

  arm_shift_core u_core (
    .req    (core_req),
    .rm     (core_rm),
    .c_in   (core_cin),
    .result (core_result),
    .carry  (core_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      bus.req_ready  <= 1'b1;
      bus.rs_rd_en   <= 1'b0;
      bus.rs_rd_addr <= 4'd0;
      bus.res_valid  <= 1'b0;
      bus.res_data   <= 32'd0;
      bus.res_carry  <= 1'b0;
      cap_type       <= SHIFT_LSL;
      cap_rm         <= 32'd0;
      cap_cin        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready  <= 1'b0;
            bus.rs_rd_addr <= bus.instr_op2[11:8];
            cap_type       <= shift_type_e'(bus.instr_op2[6:5]);
            cap_rm         <= bus.rm_data;
            cap_cin        <= bus.c_in;
            if (!bus.imm_form && bus.instr_op2[4]) begin
              bus.rs_rd_en <= 1'b1;
              state        <= ST_RS_REQ;
            end else begin
              bus.res_data  <= core_result;
              bus.res_carry <= core_carry;
              bus.res_valid <= 1'b1;
              state         <= ST_RESULT;
            end
          end
        end
        ST_RS_REQ: begin
          bus.rs_rd_en <= 1'b0;
          state        <= ST_RS_WAIT;
        end
        ST_RS_WAIT: begin
          bus.res_data  <= core_result;
          bus.res_carry <= core_carry;
          bus.res_valid <= 1'b1;
          state         <= ST_RESULT;
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
